// File: rtl/srl_start_fifo_af.sv
// srl_start_fifo_af: SRL FIFO with registered full/empty/almost-full flags and occupancy; define SRL_FIFO_OREG_EN for a head output register
module srl_start_fifo_af #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 5,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);
  typedef logic [ADDR_WIDTH:0] cnt_t;
`ifdef SRL_FIFO_OREG_EN
  localparam cnt_t CAP = cnt_t'(DEPTH + 1);
`else
  localparam cnt_t CAP = cnt_t'(DEPTH);
`endif
  localparam cnt_t AF = cnt_t'(AF_LEVEL);
  cnt_t                  cnt, cnt_nxt;
  logic                  full_n, empty_n, af_n;
  logic                  push, pop, shift;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [DATA_WIDTH-1:0] srl_head;
  assign push    = if_write & if_write_ce & full_n;
  assign pop     = if_read & if_read_ce & empty_n;
  assign cnt_nxt = (push & ~pop) ? cnt + 1'b1 : (pop & ~push) ? cnt - 1'b1 : cnt;
`ifdef SRL_FIFO_OREG_EN
  logic                  bypass;
  logic [DATA_WIDTH-1:0] hd;
  // A push lands straight in the head register when it is (or is about to become) empty
  assign bypass = push & ((cnt == '0) | ((cnt == cnt_t'(1)) & pop));
  assign shift  = push & ~bypass;
  assign ra     = ADDR_WIDTH'(cnt - cnt_t'(2));
  // Head register: load bypassed input, or refill from the SRL head on pop
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) hd <= '0;
    else if (bypass) hd <= if_din;
    else if (pop && cnt > cnt_t'(1)) hd <= srl_head;
  assign if_dout = hd;
`else
  assign shift   = push;
  assign ra      = ADDR_WIDTH'(cnt - cnt_t'(1));
  assign if_dout = srl_head;
`endif
  // Read mux selecting the oldest SRL entry from registered count only
  always_comb begin
    srl_head = srl[0];
    for (int i = 1; i < DEPTH; i++)
      if (ra == ADDR_WIDTH'(i)) srl_head = srl[i];
  end
  // Unreset shift register: new data enters entry 0, older data moves up
  always_ff @(posedge ap_clk)
    if (shift) begin
      srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  // Occupancy and flags, all derived from the next-state count
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      cnt     <= '0;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
      af_n    <= (AF != '0);
    end else begin
      cnt     <= cnt_nxt;
      full_n  <= cnt_nxt != CAP;
      empty_n <= cnt_nxt != '0;
      af_n    <= cnt_nxt < AF;
    end
  assign if_full_n         = full_n;
  assign if_empty_n        = empty_n;
  assign if_almost_full_n  = af_n;
  assign if_num_data_valid = cnt;
endmodule

// File: tb/tb_srl_start_fifo_af.sv
// tb_srl_start_fifo_af: directed and random checks of srl_start_fifo_af against a queue model
module tb_srl_start_fifo_af;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 5;
  localparam int AFL = 4;
`ifdef SRL_FIFO_OREG_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif
  logic          ap_clk = 0, ap_rst_n = 0;
  logic          if_write_ce = 0, if_write = 0, if_read_ce = 0, if_read = 0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n, if_almost_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid;
  int            cmp = 0, err = 0;
  logic [DW-1:0] q[$];

  srl_start_fifo_af #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_num_data_valid(if_num_data_valid)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(if_num_data_valid), q.size());
    chk("empty_n", 32'(if_empty_n), 32'(q.size() != 0));
    chk("full_n", 32'(if_full_n), 32'(q.size() != CAP));
    chk("almost_full_n", 32'(if_almost_full_n), 32'(q.size() < AFL));
    if (q.size() > 0) chk("dout_head", 32'(if_dout), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic wce, input logic [DW-1:0] d, input logic r, input logic rce);
    bit pu, po;
    @(negedge ap_clk);
    if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
    pu = w & wce & (q.size() < CAP);
    po = r & rce & (q.size() > 0);
    if (po) chk("dout_pop", 32'(if_dout), 32'(q[0]));
    @(posedge ap_clk);
    #1;
    if (po) void'(q.pop_front());
    if (pu) q.push_back(d);
    check_state();
  endtask

  initial begin
    repeat (2) @(posedge ap_clk);
    #1;
    check_state();
    @(negedge ap_clk);
    ap_rst_n = 1;
    for (int i = 1; i <= CAP; i++) step(1, 1, DW'(i), 0, 0);
    step(1, 1, 8'hEE, 0, 0);
    chk("count_full_hold", 32'(if_num_data_valid), CAP);
    for (int i = 0; i <= CAP; i++) step(0, 0, '0, 1, 1);
    chk("count_empty_hold", 32'(if_num_data_valid), 0);
    for (int i = 0; i < 3; i++) step(1, 1, DW'(8'h10 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, DW'(8'h20 + i), 1, 1);
    step(1, 0, 8'h55, 0, 0);
    step(0, 0, '0, 1, 0);
    step(1, 1, 8'h66, 0, 0);
    @(negedge ap_clk);
    if_write = 0; if_read = 0;
    #2 ap_rst_n = 0;
    #1;
    q.delete();
    check_state();
    step(0, 0, '0, 0, 0);
    @(negedge ap_clk);
    ap_rst_n = 1;
    step(0, 0, '0, 0, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 99) < ((k % 100) < 50 ? 75 : 25), $urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 99) < ((k % 100) < 50 ? 25 : 75), $urandom_range(0, 3) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/srl_start_fifo_af.md
# srl_start_fifo_af

Parametrised shift-register (SRL) FIFO for inter-task start tokens and narrow stream data between dataflow processes in the linear-layer kernels. It generalises the fixed SRL storage used by the start FIFOs into a complete FIFO with:

- registered full/empty flags;
- an almost-full flag with a programmable level;
- an occupancy count;
- an optional output register stage.

It sits between a producer task's start/stream output and a consumer PE's input.

## Interface
Parameters:
- DATA_WIDTH, 1, payload width in bits.
- ADDR_WIDTH, 3, SRL address width; requires 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 5, SRL storage entries, minimum 2.
- AF_LEVEL, DEPTH-1, occupancy at which if_almost_full_n deasserts, range 1..capacity.

Ports (clock and reset first):
- ap_clk  in  1  clock; all registers update on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available; registered.
- if_almost_full_n  out  1  0 when occupancy >= AF_LEVEL; registered.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  head-of-queue data; valid only while if_empty_n=1.
- if_empty_n  out  1  1 = data available; registered.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy; registered.

## Operation
- Push is accepted when if_write & if_write_ce & if_full_n.
- Pop is accepted when if_read & if_read_ce & if_empty_n.
- A write while full and a read while empty are ignored: no state change.
- Storage is an SRL without reset. On a push, every entry shifts up by one and if_din enters entry 0. The head is entry count-1.
- Occupancy update:
  - push only: count+1;
  - pop only: count-1;
  - push and pop together: count unchanged, shift still occurs, head address unchanged.
- Flags are recomputed from the next-state count: full_n = (count_next != capacity), empty_n = (count_next != 0), almost_full_n = (count_next < AF_LEVEL).
- Capacity is DEPTH, or DEPTH+1 with the output register compiled in.
- Reset (asynchronous assertion, synchronous deassertion edge is irrelevant to the block): count=0, if_full_n=1, if_almost_full_n=1 (0 if AF_LEVEL would be reached at 0, which is illegal), if_empty_n=0, if_num_data_valid=0. SRL contents are not cleared.
- Reset mid-operation discards all queued data. The flags reach reset values immediately, without waiting for a clock edge.

## Timing
- Latency from write to read: a push at edge k gives if_empty_n=1 after edge k; it is poppable at edge k+1.
- Latency from read to write: a pop at edge k gives if_full_n=1 after edge k.
- No combinational path from if_write/if_read to any flag.
- Without output register: if_dout = SRL[count-1], a combinational mux from registered state only.
- Simultaneous push and pop is legal when 0 < count < capacity.
  - When full, only pop is accepted; a push in the same cycle is refused.
  - When empty, only push is accepted.

## Configuration
- SRL_FIFO_OREG_EN defined: adds a head register driving if_dout. Capacity becomes DEPTH+1.
  - Bypass: a push into an empty FIFO, or into a FIFO whose only word is being popped, writes if_din directly into the head register. Write-to-read latency therefore stays 1 cycle.
  - On pop with SRL non-empty, the head register loads the SRL head in the same edge.
  - The head register resets to 0.
- SRL_FIFO_OREG_EN undefined: no head register; if_dout is the SRL mux described above; capacity is DEPTH.

## Test plan
- Reset, then fill: DEPTH=5, push 5 words 0x1..0x5 → if_full_n=0 after the 5th edge; if_almost_full_n=0 after the 4th; if_num_data_valid=5; a 6th push is ignored.
- Drain in order: pop 5 times → if_dout sequence 1,2,3,4,5; if_empty_n=0 after the 5th pop; a 6th pop is ignored and the count stays 0.
- Simultaneous push and pop at count=3 for 10 cycles → count stays 3; output order is preserved; the flags never toggle.
- Clock-enable gating: if_write=1 with if_write_ce=0 → no count change; same check for the read side.
- Asynchronous reset asserted mid-cycle with count=4 → the flags return to reset values before the next edge; after release, if_empty_n=0.
- With SRL_FIFO_OREG_EN: push 0xA into empty → if_dout=0xA and if_empty_n=1 after 1 edge; fill to 6 → if_full_n=0; back-to-back pops drain all 6 words in order.
